// File: rtl/ps2_host_tx_if.sv
`timescale 1ns/1ps
// Command handshake and transfer status between the PS/2 host transmitter
// and its client (mouse init sequencer or testbench).
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame
// clocked by the device, ack check, per-edge timeout. Open-collector via OEs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | tx_ready high, waiting for a command byte
//   INHIBIT   | holding PS2Clk low for INHIBIT_CYCLES
//   RTS       | one cycle with clock and data both low (start bit)
//   SEND      | shifting d0..d7, parity, stop on device clock falls
//   ACK       | sampling the device ack bit on the 11th fall
//   WAIT_IDLE | waiting for both lines to return high, then done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_host_tx_if.slave   bus,
    input  logic           ps2_clk_i,
    input  logic           ps2_data_i,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic            clk_meta, clk_sync, data_meta, data_sync;
    logic            clk_filt, clk_filt_q;
    logic [FW-1:0]   flt_cnt;
    logic [CW-1:0]   timer;
    logic [9:0]      frame;
    logic [3:0]      bit_idx;
    logic            tx_ready_r, done_r, ack_err_r, timeout_err_r;
    logic            fall;
    logic            tmo_hit;

    // Synchronizers reset to the idle (released, pulled-up) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            data_meta  <= 1'b1;
            data_sync  <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_meta   <= ps2_clk_i;
            clk_sync   <= clk_meta;
            data_meta  <= ps2_data_i;
            data_sync  <= data_meta;
            clk_filt_q <= clk_filt;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_filt_q & ~clk_filt;
    assign tmo_hit = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE))
                     && !fall && (timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ps2_clk_oe    <= 1'b0;
            ps2_data_oe   <= 1'b0;
            tx_ready_r    <= 1'b1;
            done_r        <= 1'b0;
            ack_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            timer         <= '0;
            frame         <= '0;
            bit_idx       <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        frame         <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        ack_err_r     <= 1'b0;
                        timeout_err_r <= 1'b0;
                        tx_ready_r    <= 1'b0;
                        ps2_clk_oe    <= 1'b1;
                        timer         <= CW'(INHIBIT_CYCLES - 1);
                        state         <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == '0) begin
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RTS: begin
                    ps2_clk_oe <= 1'b0;
                    timer      <= CW'(TIMEOUT_CYCLES - 1);
                    bit_idx    <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (fall) begin
                        timer       <= CW'(TIMEOUT_CYCLES - 1);
                        ps2_data_oe <= ~frame[bit_idx];
                        if (bit_idx == 4'd9) begin
                            state <= ACK;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ACK: begin
                    if (fall) begin
                        timer     <= CW'(TIMEOUT_CYCLES - 1);
                        ack_err_r <= data_sync;
                        state     <= WAIT_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (fall) begin
                        timer <= CW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                    if (clk_filt && data_sync) begin
                        done_r     <= 1'b1;
                        tx_ready_r <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase

            // A silent device aborts the transfer from any clocked phase.
            if (tmo_hit) begin
                ps2_clk_oe    <= 1'b0;
                ps2_data_oe   <= 1'b0;
                timeout_err_r <= 1'b1;
                done_r        <= 1'b1;
                tx_ready_r    <= 1'b1;
                timer         <= '0;
                state         <= IDLE;
            end
        end
    end

    assign bus.tx_ready    = tx_ready_r;
    assign bus.done        = done_r;
    assign bus.ack_err     = ack_err_r;
    assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: behavioural PS/2 device, accept watcher feeding a
// scoreboard, and a done monitor comparing status and captured line frames.
module tb_ps2_host_tx;

    localparam int INH = 120;
    localparam int TMO = 2000;
    localparam int FLT = 8;
    localparam int H   = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_i, ps2_data_i;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch_low   = 1'b0;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        logic [10:0] frame;
        bit          ack;
        bit          tmo;
        bit          chk_frame;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    bit          cur_ack = 1'b0;
    bit          cur_tmo = 1'b0;
    bit          dev_en = 1'b1;
    int          glitch_fall = 0;
    int          dev_falls = 0;
    logic [10:0] dev_frame = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line frame as a device sees it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Accept watcher: anything the DUT will take at the next edge is expected.
    always @(negedge clk) begin
        if (rst_n && bus.tx_valid && bus.tx_ready)
            sb.push_back('{ref_frame(bus.tx_data), cur_ack, cur_tmo, !cur_tmo});
    end

    // Done monitor.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_count++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done t=%0t", $time);
            end else begin
                e = sb.pop_front();
                chk("ack_err", bus.ack_err, e.ack);
                chk("timeout_err", bus.timeout_err, e.tmo);
                chk("ready_at_done", bus.tx_ready, 1);
                if (e.chk_frame) chk("line_frame", dev_frame, e.frame);
            end
        end
    end

    // Device model: detects request-to-send, clocks 11 pulses, samples host
    // bits on rising edges and answers ACK/NACK from cur_ack.
    initial begin
        bit aborted;
        forever begin
            @(negedge clk);
            if (dev_en && rst_n && ps2_clk_i && !ps2_data_i && !dev_clk_low && !dev_data_low) begin
                dev_frame    = '0;
                dev_frame[0] = ps2_data_i;
                dev_falls    = 0;
                aborted      = 1'b0;
                repeat (H) @(negedge clk);
                for (int k = 1; k <= 11 && !aborted; k++) begin
                    dev_clk_low = 1'b1;
                    dev_falls   = k;
                    chk("clk_oe_released_while_device_clocks", ps2_clk_oe, 0);
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) dev_frame[k] = ps2_data_i;
                    if (k == 10) dev_data_low = !cur_ack;
                    if (k == 11) dev_data_low = 1'b0;
                    if (k == glitch_fall) begin
                        repeat (10) @(negedge clk);
                        glitch_low = 1'b1;
                        repeat (5) @(negedge clk);
                        glitch_low = 1'b0;
                        repeat (H - 15) @(negedge clk);
                    end else begin
                        repeat (H) @(negedge clk);
                    end
                    if (!rst_n) aborted = 1'b1;
                end
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(posedge clk); #1;
        while (!bus.tx_ready && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tx_ready_within_budget", bus.tx_ready, 1);
    endtask

    task automatic wait_done(input int start_cnt, input int budget);
        int n = 0;
        while (done_count == start_cnt && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_within_budget", (done_count != start_cnt), 1);
    endtask

    task automatic issue(input logic [7:0] d, input bit ack);
        wait_ready();
        cur_ack      = ack;
        cur_tmo      = 1'b0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit ack);
        int start;
        start = done_count;
        issue(d, ack);
        wait_done(start, INH + 30 * H + 500);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n, n_inh, n_rts, rel;
        logic [7:0] rd;
        bit ra;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;

        repeat (3) @(negedge clk);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack_err", bus.ack_err, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hF4, 1'b0);
        send(8'hFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            send(rd, ra);
        end

        glitch_fall = 4;
        send(8'h5A, 1'b0);
        glitch_fall = 0;

        // Silent device: inhibit timing and edge timeout.
        dev_en  = 1'b0;
        wait_ready();
        cur_ack = 1'b0;
        cur_tmo = 1'b1;
        start   = done_count;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        n_inh = 0;
        n_rts = 0;
        n     = 0;
        @(negedge clk);
        while (ps2_clk_oe && n < INH + 50) begin
            if (ps2_data_oe) n_rts++;
            else n_inh++;
            @(negedge clk);
            n++;
        end
        rel = cyc;
        chk("inhibit_cycles", n_inh, INH);
        chk("rts_cycles", n_rts, 1);
        chk("start_bit_held_after_release", ps2_data_oe, 1);
        wait_done(start, TMO + 200);
        chk("timeout_latency", ((done_cyc - rel) >= TMO - 1) && ((done_cyc - rel) <= TMO + 1), 1);
        @(negedge clk);
        chk("tmo_clk_oe", ps2_clk_oe, 0);
        chk("tmo_data_oe", ps2_data_oe, 0);
        dev_en  = 1'b1;
        cur_tmo = 1'b0;
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of a transfer.
        dev_falls = 0;
        issue(8'hF4, 1'b0);
        n = 0;
        while (dev_falls < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("data_oe_before_reset", ps2_data_oe, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 0);
        chk("async_rst_data_oe", ps2_data_oe, 0);
        chk("async_rst_tx_ready", bus.tx_ready, 1);
        chk("async_rst_done", bus.done, 0);
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        send(8'hF4, 1'b0);

        // tx_valid held with new data during a transfer.
        wait_ready();
        start        = done_count;
        cur_ack      = 1'b0;
        cur_tmo      = 1'b0;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_data  = 8'hA5;
        n = 0;
        while (done_count < start + 2 && n < 8000) begin
            @(posedge clk); #1;
            if (done_count == start + 1 && !bus.tx_ready) bus.tx_valid = 1'b0;
            n++;
        end
        bus.tx_valid = 1'b0;
        chk("held_valid_transfers", done_count - start, 2);
        repeat (20) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
